// File: rtl/cla_nibble_serial_adder_pkg.sv
// cla_nibble_serial_adder_pkg: shared FSM states, nibble width and index-width helper
package cla_nibble_serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction
endpackage

// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: 4-bit adder with carries computed from generate/propagate terms
module carry_look_ahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] SUM,
    output logic       Cout
);
    logic [3:0] p, g;
    logic [4:0] c;
    assign p = A ^ B;
    assign g = A & B;
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign SUM  = p ^ c[3:0];
    assign Cout = c[4];
endmodule

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit add computed one nibble per clock through a single 4-bit CLA
module cla_nibble_serial_adder
    import cla_nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic carry_reg, nib_cout, accept, last;
    logic [NIBBLE_W-1:0] nib_sum;

    assign accept = start && (state != ADD);
    assign last   = (idx == LAST);
    assign busy   = (state == ADD);
    assign done   = (state == DONE);

    carry_look_ahead_adder u_cla (
        .A    (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .B    (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .Cin  (carry_reg),
        .SUM  (nib_sum),
        .Cout (nib_cout)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = accept ? ADD : (state == ADD) ? (last ? DONE : ADD) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            carry_reg <= cin;
            a_reg     <= a;
            b_reg     <= b;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == ADD) begin
            sum[NIBBLE_W*idx +: NIBBLE_W] <= nib_sum;
            carry_reg <= nib_cout;
            idx       <= last ? '0 : idx + 1'b1;
            // the top nibble's sum bit is the result sign bit
            if (last) begin
                cout     <= nib_cout;
                overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: scoreboard bench against an integer-arithmetic reference model
module tb_cla_nibble_serial_adder;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic busy, done, cout, overflow;
    logic [15:0] sum;
    logic s4_start = 1'b0, s4_cin = 1'b0;
    logic [3:0] s4_a = '0, s4_b = '0;
    logic s4_busy, s4_done, s4_cout, s4_ovf;
    logic [3:0] s4_sum;
    int passed = 0, total = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    cla_nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
        .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout), .overflow(s4_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {overflow, cout, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        int r;
        full = 17'(x) + 17'(y) + 17'(c);
        r = int'($signed(x)) + int'($signed(y)) + int'(c);
        return {(r > 32767) || (r < -32768), full};
    endfunction

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
        start = 1'b1; a = x; b = y; cin = c;
        exp_q.push_back(model(x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = -1; bc = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) bc++;
            if (done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin : monitor
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(e[15:0]));
                    chk("cout", 32'(cout), 32'(e[16]));
                    chk("overflow", 32'(overflow), 32'(e[17]));
                end
            end
        end
    end

    initial begin
        int lat, bc;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_flags", {30'd0, cout, overflow}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        send(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat, bc);
        chk("latency", 32'(lat), 5);
        chk("busy_cycles", 32'(bc), 4);
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 0);

        send(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat, bc);
        send(16'h8000, 16'h8000, 1'b0);
        wait_done(lat, bc);
        chk("b2b_latency", 32'(lat), 5);

        send(16'h1234, 16'h4321, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0; a = 16'h0;
        wait_done(lat, bc);
        send(16'h0001, 16'h0001, 1'b0);
        wait_done(lat, bc);
        chk("held_start_latency", 32'(lat), 5);
        @(posedge clk); #1;

        send(16'hABCD, 16'h1111, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_sum", 32'(sum), 0);
        chk("arst_flags", {30'd0, cout, overflow}, 0);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("no_done_after_rst", 32'(done), 0);
        send(16'h00FF, 16'h0F01, 1'b1);
        wait_done(lat, bc);
        chk("post_rst_latency", 32'(lat), 5);

        s4_start = 1'b1; s4_a = 4'hA; s4_b = 4'h5; s4_cin = 1'b1;
        @(posedge clk); #1 s4_start = 1'b0;
        chk("w4_busy", {30'd0, s4_busy, s4_done}, 32'b10);
        @(posedge clk); #1;
        chk("w4_done", 32'(s4_done), 1);
        chk("w4_sum", 32'(s4_sum), 0);
        chk("w4_cout", 32'(s4_cout), 1);
        chk("w4_ovf", 32'(s4_ovf), 0);

        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(lat, bc);
            if (lat < 0) break;
        end
        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
